tuner_ctrl_seq: RTL and testbench

Per-ring tuner sequencer. It triggers the search PHY, converts the found peak into lock configuration, triggers the lock PHY, and then issues periodic track requests. It owns the mux that drives the ring DAC code from whichever PHY is active. It counts failed attempts and parks in ERROR once the retry budget is exhausted.

---
 rtl/tuner_ctrl_seq_pkg.sv | 29 ++
 rtl/tuner_track_timer.sv | 39 +++
 rtl/tuner_ctrl_seq.sv | 166 ++++++++++++++++
 tb/tb_tuner_ctrl_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tuner_ctrl_seq_pkg.sv
// Shared tuner package: sequencer state encoding and phase helpers.
package tuner_ctrl_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE        = 3'd0,
    SEQ_SEARCH_TRIG = 3'd1,
    SEQ_SEARCH_WAIT = 3'd2,
    SEQ_LOCK_TRIG   = 3'd3,
    SEQ_LOCK_WAIT   = 3'd4,
    SEQ_TRACK       = 3'd5,
    SEQ_ERROR       = 3'd6
  } tuner_ctrl_seq_state_e;

  localparam int unsigned DEF_DAC_WIDTH   = 8;
  localparam int unsigned DEF_ADC_WIDTH   = 8;
  localparam int unsigned DEF_TIMER_WIDTH = 16;
  localparam int unsigned DEF_RETRY_WIDTH = 4;

  // True while the search PHY owns the ring DAC.
  function automatic logic is_search_phase(input tuner_ctrl_seq_state_e st);
    return (st == SEQ_SEARCH_TRIG) || (st == SEQ_SEARCH_WAIT);
  endfunction

  // True while the lock PHY owns the ring DAC.
  function automatic logic is_lock_phase(input tuner_ctrl_seq_state_e st);
    return (st == SEQ_LOCK_TRIG) || (st == SEQ_LOCK_WAIT) || (st == SEQ_TRACK);
  endfunction

endpackage

// File: rtl/tuner_track_timer.sv
// Loadable down-counter that raises a held request every 'period' cycles.
module tuner_track_timer #(
  parameter int TIMER_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   load,
  input  logic                   run,
  input  logic [TIMER_WIDTH-1:0] period,
  input  logic                   ack,
  output logic                   req
);

  logic [TIMER_WIDTH-1:0] count;

  // Count down while idle-running; a count of 1 becomes a request that holds until acked, then reloads.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count <= '0;
      req   <= 1'b0;
    end else if (load) begin
      count <= period;
      req   <= 1'b0;
    end else if (!run) begin
      req <= 1'b0;
    end else if (req) begin
      if (ack) begin
        req   <= 1'b0;
        count <= period;
      end
    end else if (count != '0) begin
      count <= count - 1'b1;
      if (count == TIMER_WIDTH'(1)) begin
        req <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tuner_ctrl_seq.sv
// Per-ring tuner sequencer: search, lock, periodic track, with retry budget and DAC ownership mux.
module tuner_ctrl_seq
  import tuner_ctrl_seq_pkg::*;
#(
  parameter int DAC_WIDTH   = 8,
  parameter int ADC_WIDTH   = 8,
  parameter int TIMER_WIDTH = 16,
  parameter int RETRY_WIDTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cfg_en,
  input  logic [DAC_WIDTH-1:0]   i_cfg_red_offset,
  input  logic [TIMER_WIDTH-1:0] i_cfg_track_period,
  input  logic [RETRY_WIDTH-1:0] i_cfg_retry_max,
  output logic                   o_search_trig_val,
  input  logic                   i_search_trig_rdy,
  input  logic                   i_search_done_val,
  output logic                   o_search_done_rdy,
  input  logic                   i_search_peak_found,
  input  logic [DAC_WIDTH-1:0]   i_search_peak_code,
  input  logic [ADC_WIDTH-1:0]   i_search_peak_pwr,
  input  logic [DAC_WIDTH-1:0]   i_search_ring_tune,
  output logic                   o_lock_trig_val,
  input  logic                   i_lock_trig_rdy,
  input  logic                   i_lock_done_val,
  output logic                   o_lock_done_rdy,
  output logic                   o_lock_track_val,
  input  logic                   i_lock_track_rdy,
  input  logic                   i_lock_err,
  input  logic [DAC_WIDTH-1:0]   i_lock_ring_tune,
  output logic [DAC_WIDTH-1:0]   o_cfg_ring_tune_start,
  output logic [ADC_WIDTH-1:0]   o_cfg_ring_pwr_peak,
  output logic [DAC_WIDTH-1:0]   o_dig_ring_tune,
  output logic [2:0]             o_state,
  output logic                   o_locked,
  output logic                   o_err
);

  tuner_ctrl_seq_state_e state_q, state_d;

  logic [RETRY_WIDTH-1:0] retry_cnt;
  logic                   retry_exhausted;
  logic                   fail_evt;
  logic                   retry_clr;
  logic                   latch_cfg;
  logic                   timer_load;
  logic                   track_req;
  logic                   search_trig_fire;
  logic                   search_done_fire;
  logic                   lock_trig_fire;
  logic                   lock_done_fire;
  logic                   track_fire;
  logic [DAC_WIDTH-1:0]   tune_start_calc;

  assign o_search_trig_val = (state_q == SEQ_SEARCH_TRIG);
  assign o_search_done_rdy = (state_q == SEQ_SEARCH_WAIT);
  assign o_lock_trig_val   = (state_q == SEQ_LOCK_TRIG);
  assign o_lock_done_rdy   = (state_q == SEQ_LOCK_WAIT);
  assign o_lock_track_val  = track_req && (state_q == SEQ_TRACK);
  assign o_locked          = (state_q == SEQ_TRACK);
  assign o_err             = (state_q == SEQ_ERROR);
  assign o_state           = state_q;

  assign search_trig_fire = o_search_trig_val & i_search_trig_rdy;
  assign search_done_fire = o_search_done_rdy & i_search_done_val;
  assign lock_trig_fire   = o_lock_trig_val & i_lock_trig_rdy;
  assign lock_done_fire   = o_lock_done_rdy & i_lock_done_val;
  assign track_fire       = o_lock_track_val & i_lock_track_rdy;

  assign retry_exhausted = (retry_cnt == i_cfg_retry_max);

  // Red-side start code never wraps below zero.
  assign tune_start_calc = (i_search_peak_code >= i_cfg_red_offset) ?
                           (i_search_peak_code - i_cfg_red_offset) : '0;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= SEQ_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; disable wins over everything, lock error wins over same-cycle done/track fires.
  always_comb begin
    state_d    = state_q;
    fail_evt   = 1'b0;
    retry_clr  = 1'b0;
    latch_cfg  = 1'b0;
    timer_load = 1'b0;
    if (!i_cfg_en) begin
      state_d = SEQ_IDLE;
    end else begin
      unique case (state_q)
        SEQ_IDLE: begin
          state_d   = SEQ_SEARCH_TRIG;
          retry_clr = 1'b1;
        end
        SEQ_SEARCH_TRIG: if (search_trig_fire) state_d = SEQ_SEARCH_WAIT;
        SEQ_SEARCH_WAIT: begin
          if (search_done_fire) begin
            if (i_search_peak_found) begin
              latch_cfg = 1'b1;
              state_d   = SEQ_LOCK_TRIG;
            end else begin
              fail_evt = 1'b1;
            end
          end
        end
        SEQ_LOCK_TRIG: begin
          if (i_lock_err)          fail_evt = 1'b1;
          else if (lock_trig_fire) state_d  = SEQ_LOCK_WAIT;
        end
        SEQ_LOCK_WAIT: begin
          if (i_lock_err) begin
            fail_evt = 1'b1;
          end else if (lock_done_fire) begin
            timer_load = 1'b1;
            state_d    = SEQ_TRACK;
          end
        end
        SEQ_TRACK: if (i_lock_err) fail_evt = 1'b1;
        SEQ_ERROR: state_d = SEQ_ERROR;
        default:   state_d = SEQ_IDLE;
      endcase
      if (fail_evt) state_d = retry_exhausted ? SEQ_ERROR : SEQ_SEARCH_TRIG;
    end
  end

  // Failed-attempt counter, cleared each time a fresh sequence starts from IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst)                            retry_cnt <= '0;
    else if (retry_clr)                   retry_cnt <= '0;
    else if (fail_evt && !retry_exhausted) retry_cnt <= retry_cnt + 1'b1;
  end

  // Lock configuration captured from a successful search result; survives aborts.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cfg_ring_tune_start <= '0;
      o_cfg_ring_pwr_peak   <= '0;
    end else if (latch_cfg) begin
      o_cfg_ring_tune_start <= tune_start_calc;
      o_cfg_ring_pwr_peak   <= i_search_peak_pwr;
    end
  end

  // Ring DAC follows whichever PHY owns the current phase; otherwise it holds.
  always_ff @(posedge i_clk) begin
    if (i_rst)                         o_dig_ring_tune <= '0;
    else if (is_search_phase(state_q)) o_dig_ring_tune <= i_search_ring_tune;
    else if (is_lock_phase(state_q))   o_dig_ring_tune <= i_lock_ring_tune;
  end

  tuner_track_timer #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_track_timer (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .load  (timer_load),
    .run   (state_q == SEQ_TRACK),
    .period(i_cfg_track_period),
    .ack   (track_fire),
    .req   (track_req)
  );

endmodule

// File: tb/tb_tuner_ctrl_seq.sv
// Directed self-checking bench for tuner_ctrl_seq.
module tb_tuner_ctrl_seq;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cfg_en;
  logic [7:0]  i_cfg_red_offset;
  logic [15:0] i_cfg_track_period;
  logic [3:0]  i_cfg_retry_max;
  logic        o_search_trig_val, i_search_trig_rdy;
  logic        i_search_done_val, o_search_done_rdy;
  logic        i_search_peak_found;
  logic [7:0]  i_search_peak_code, i_search_peak_pwr, i_search_ring_tune;
  logic        o_lock_trig_val, i_lock_trig_rdy;
  logic        i_lock_done_val, o_lock_done_rdy;
  logic        o_lock_track_val, i_lock_track_rdy;
  logic        i_lock_err;
  logic [7:0]  i_lock_ring_tune;
  logic [7:0]  o_cfg_ring_tune_start, o_cfg_ring_pwr_peak, o_dig_ring_tune;
  logic [2:0]  o_state;
  logic        o_locked, o_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  tuner_ctrl_seq dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cfg_en(i_cfg_en),
    .i_cfg_red_offset(i_cfg_red_offset), .i_cfg_track_period(i_cfg_track_period),
    .i_cfg_retry_max(i_cfg_retry_max),
    .o_search_trig_val(o_search_trig_val), .i_search_trig_rdy(i_search_trig_rdy),
    .i_search_done_val(i_search_done_val), .o_search_done_rdy(o_search_done_rdy),
    .i_search_peak_found(i_search_peak_found), .i_search_peak_code(i_search_peak_code),
    .i_search_peak_pwr(i_search_peak_pwr), .i_search_ring_tune(i_search_ring_tune),
    .o_lock_trig_val(o_lock_trig_val), .i_lock_trig_rdy(i_lock_trig_rdy),
    .i_lock_done_val(i_lock_done_val), .o_lock_done_rdy(o_lock_done_rdy),
    .o_lock_track_val(o_lock_track_val), .i_lock_track_rdy(i_lock_track_rdy),
    .i_lock_err(i_lock_err), .i_lock_ring_tune(i_lock_ring_tune),
    .o_cfg_ring_tune_start(o_cfg_ring_tune_start), .o_cfg_ring_pwr_peak(o_cfg_ring_pwr_peak),
    .o_dig_ring_tune(o_dig_ring_tune), .o_state(o_state), .o_locked(o_locked), .o_err(o_err)
  );

  // Free-running clock.
  always #5 i_clk = ~i_clk;

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fire_search_trig();
    i_search_trig_rdy = 1'b1; tick(); i_search_trig_rdy = 1'b0;
  endtask

  task automatic fire_search_done(input logic found, input logic [7:0] code, input logic [7:0] pwr);
    i_search_done_val = 1'b1; i_search_peak_found = found;
    i_search_peak_code = code; i_search_peak_pwr = pwr;
    tick();
    i_search_done_val = 1'b0; i_search_peak_found = 1'b0;
  endtask

  task automatic fire_lock_trig();
    i_lock_trig_rdy = 1'b1; tick(); i_lock_trig_rdy = 1'b0;
  endtask

  task automatic fire_lock_done();
    i_lock_done_val = 1'b1; tick(); i_lock_done_val = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_cfg_en = 1'b0;
    tick(); tick();
    chk_cnt++; if (o_state !== 3'd0) $display("[TB] FAIL reset_state got %0d want 0", o_state); else pass_cnt++;
    chk_cnt++; if ({o_search_trig_val, o_search_done_rdy, o_lock_trig_val, o_lock_done_rdy, o_lock_track_val} !== 5'b0)
      $display("[TB] FAIL reset_vals got %b want 00000", {o_search_trig_val, o_search_done_rdy, o_lock_trig_val, o_lock_done_rdy, o_lock_track_val}); else pass_cnt++;
    chk_cnt++; if ({o_locked, o_err, o_dig_ring_tune, o_cfg_ring_tune_start, o_cfg_ring_pwr_peak} !== 26'd0)
      $display("[TB] FAIL reset_data got lk=%b er=%b dig=%0d ts=%0d pw=%0d want all 0", o_locked, o_err, o_dig_ring_tune, o_cfg_ring_tune_start, o_cfg_ring_pwr_peak); else pass_cnt++;
    i_rst = 1'b0;
  endtask

  task automatic test_nominal();
    i_cfg_red_offset = 8'd16; i_cfg_track_period = 16'd0; i_cfg_retry_max = 4'd3;
    i_cfg_en = 1'b1; tick();
    chk_cnt++; if (o_state !== 3'd1 || o_search_trig_val !== 1'b1) $display("[TB] FAIL nom_search_trig got st=%0d val=%b want 1/1", o_state, o_search_trig_val); else pass_cnt++;
    fire_search_trig();
    chk_cnt++; if (o_state !== 3'd2 || o_search_done_rdy !== 1'b1) $display("[TB] FAIL nom_search_wait got st=%0d rdy=%b want 2/1", o_state, o_search_done_rdy); else pass_cnt++;
    chk_cnt++; if (o_dig_ring_tune !== 8'h11) $display("[TB] FAIL nom_dig_search got %0h want 11", o_dig_ring_tune); else pass_cnt++;
    fire_search_done(1'b1, 8'd100, 8'd200);
    chk_cnt++; if (o_cfg_ring_tune_start !== 8'd84 || o_cfg_ring_pwr_peak !== 8'd200)
      $display("[TB] FAIL nom_cfg got ts=%0d pw=%0d want 84/200", o_cfg_ring_tune_start, o_cfg_ring_pwr_peak); else pass_cnt++;
    chk_cnt++; if (o_state !== 3'd3 || o_lock_trig_val !== 1'b1) $display("[TB] FAIL nom_lock_trig got st=%0d val=%b want 3/1", o_state, o_lock_trig_val); else pass_cnt++;
    fire_lock_trig();
    chk_cnt++; if (o_state !== 3'd4 || o_dig_ring_tune !== 8'h22) $display("[TB] FAIL nom_lock_wait got st=%0d dig=%0h want 4/22", o_state, o_dig_ring_tune); else pass_cnt++;
    fire_lock_done();
    chk_cnt++; if (o_state !== 3'd5 || o_locked !== 1'b1 || o_lock_track_val !== 1'b0)
      $display("[TB] FAIL nom_track got st=%0d lk=%b tv=%b want 5/1/0", o_state, o_locked, o_lock_track_val); else pass_cnt++;
  endtask

  task automatic test_saturation();
    i_cfg_en = 1'b0; tick();
    chk_cnt++; if (o_state !== 3'd0 || o_locked !== 1'b0 || o_cfg_ring_tune_start !== 8'd84)
      $display("[TB] FAIL sat_abort got st=%0d lk=%b ts=%0d want 0/0/84", o_state, o_locked, o_cfg_ring_tune_start); else pass_cnt++;
    i_cfg_en = 1'b1; tick();
    fire_search_trig();
    fire_search_done(1'b1, 8'd10, 8'd55);
    chk_cnt++; if (o_state !== 3'd3 || o_cfg_ring_tune_start !== 8'd0 || o_cfg_ring_pwr_peak !== 8'd55)
      $display("[TB] FAIL sat_cfg got st=%0d ts=%0d pw=%0d want 3/0/55", o_state, o_cfg_ring_tune_start, o_cfg_ring_pwr_peak); else pass_cnt++;
  endtask

  task automatic test_tracking();
    i_cfg_track_period = 16'd5; i_lock_track_rdy = 1'b0;
    fire_lock_trig();
    fire_lock_done();
    for (int i = 0; i < 4; i++) tick();
    chk_cnt++; if (o_lock_track_val !== 1'b0) $display("[TB] FAIL trk_early got %b want 0", o_lock_track_val); else pass_cnt++;
    tick();
    chk_cnt++; if (o_lock_track_val !== 1'b1) $display("[TB] FAIL trk_assert got %b want 1", o_lock_track_val); else pass_cnt++;
    for (int i = 0; i < 3; i++) tick();
    chk_cnt++; if (o_lock_track_val !== 1'b1) $display("[TB] FAIL trk_hold got %b want 1", o_lock_track_val); else pass_cnt++;
    i_lock_track_rdy = 1'b1; tick(); i_lock_track_rdy = 1'b0;
    chk_cnt++; if (o_lock_track_val !== 1'b0 || o_state !== 3'd5) $display("[TB] FAIL trk_fire got tv=%b st=%0d want 0/5", o_lock_track_val, o_state); else pass_cnt++;
    for (int i = 0; i < 4; i++) tick();
    chk_cnt++; if (o_lock_track_val !== 1'b0) $display("[TB] FAIL trk_reload_early got %b want 0", o_lock_track_val); else pass_cnt++;
    tick();
    chk_cnt++; if (o_lock_track_val !== 1'b1) $display("[TB] FAIL trk_reload got %b want 1", o_lock_track_val); else pass_cnt++;
    i_lock_track_rdy = 1'b1; tick(); i_lock_track_rdy = 1'b0;
  endtask

  task automatic test_retry();
    i_cfg_en = 1'b0; tick();
    i_cfg_retry_max = 4'd2;
    i_cfg_en = 1'b1; tick();
    for (int a = 1; a <= 3; a++) begin
      fire_search_trig();
      fire_search_done(1'b0, 8'd0, 8'd0);
      if (a < 3) begin
        chk_cnt++; if (o_state !== 3'd1) $display("[TB] FAIL retry_attempt%0d got st=%0d want 1", a, o_state); else pass_cnt++;
      end
    end
    chk_cnt++; if (o_state !== 3'd6 || o_err !== 1'b1) $display("[TB] FAIL retry_error got st=%0d err=%b want 6/1", o_state, o_err); else pass_cnt++;
    i_search_ring_tune = 8'h33; tick();
    chk_cnt++; if (o_state !== 3'd6 || o_dig_ring_tune !== 8'h11) $display("[TB] FAIL err_hold got st=%0d dig=%0h want 6/11", o_state, o_dig_ring_tune); else pass_cnt++;
    i_search_ring_tune = 8'h11;
    i_cfg_en = 1'b0; tick();
    chk_cnt++; if (o_state !== 3'd0 || o_err !== 1'b0) $display("[TB] FAIL err_exit got st=%0d err=%b want 0/0", o_state, o_err); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    i_cfg_retry_max = 4'd1;
    i_cfg_en = 1'b1; tick();
    fire_search_trig();
    fire_search_done(1'b1, 8'd100, 8'd200);
    fire_lock_trig();
    i_lock_done_val = 1'b1; i_lock_err = 1'b1; tick();
    i_lock_done_val = 1'b0; i_lock_err = 1'b0;
    chk_cnt++; if (o_state !== 3'd1 || o_locked !== 1'b0) $display("[TB] FAIL sim_fail_path got st=%0d lk=%b want 1/0", o_state, o_locked); else pass_cnt++;
    fire_search_trig();
    fire_search_done(1'b0, 8'd0, 8'd0);
    chk_cnt++; if (o_state !== 3'd6) $display("[TB] FAIL sim_retry_inc got st=%0d want 6", o_state); else pass_cnt++;
    i_cfg_en = 1'b0; tick();
  endtask

  task automatic test_abort();
    i_cfg_retry_max = 4'd3;
    i_cfg_en = 1'b1; tick();
    fire_search_trig();
    chk_cnt++; if (o_search_done_rdy !== 1'b1) $display("[TB] FAIL abort_pre got %b want 1", o_search_done_rdy); else pass_cnt++;
    i_cfg_en = 1'b0; tick();
    chk_cnt++; if (o_state !== 3'd0 || {o_search_trig_val, o_search_done_rdy, o_lock_trig_val, o_lock_done_rdy, o_lock_track_val} !== 5'b0)
      $display("[TB] FAIL abort_idle got st=%0d vals=%b want 0/00000", o_state, {o_search_trig_val, o_search_done_rdy, o_lock_trig_val, o_lock_done_rdy, o_lock_track_val}); else pass_cnt++;
    chk_cnt++; if (o_cfg_ring_tune_start !== 8'd84) $display("[TB] FAIL abort_cfg_kept got %0d want 84", o_cfg_ring_tune_start); else pass_cnt++;
    i_cfg_track_period = 16'd3;
    i_cfg_en = 1'b1; tick();
    fire_search_trig();
    fire_search_done(1'b1, 8'd50, 8'd77);
    fire_lock_trig();
    fire_lock_done();
    for (int i = 0; i < 3; i++) tick();
    chk_cnt++; if (o_lock_track_val !== 1'b1 || o_locked !== 1'b1) $display("[TB] FAIL rst_pre got tv=%b lk=%b want 1/1", o_lock_track_val, o_locked); else pass_cnt++;
    i_rst = 1'b1; tick();
    chk_cnt++; if (o_state !== 3'd0 || o_locked !== 1'b0 || o_lock_track_val !== 1'b0 || o_dig_ring_tune !== 8'd0 ||
                   o_cfg_ring_tune_start !== 8'd0 || o_cfg_ring_pwr_peak !== 8'd0)
      $display("[TB] FAIL rst_mid_track got st=%0d lk=%b tv=%b dig=%0d ts=%0d pw=%0d want all 0", o_state, o_locked, o_lock_track_val, o_dig_ring_tune, o_cfg_ring_tune_start, o_cfg_ring_pwr_peak); else pass_cnt++;
    i_rst = 1'b0; i_cfg_en = 1'b0; tick();
  endtask

  // Scenario sequence.
  initial begin
    i_rst = 1'b1; i_cfg_en = 1'b0; i_cfg_red_offset = '0; i_cfg_track_period = '0; i_cfg_retry_max = '0;
    i_search_trig_rdy = 1'b0; i_search_done_val = 1'b0; i_search_peak_found = 1'b0;
    i_search_peak_code = '0; i_search_peak_pwr = '0; i_search_ring_tune = 8'h11;
    i_lock_trig_rdy = 1'b0; i_lock_done_val = 1'b0; i_lock_track_rdy = 1'b0; i_lock_err = 1'b0;
    i_lock_ring_tune = 8'h22;
    test_reset();
    test_nominal();
    test_saturation();
    test_tracking();
    test_retry();
    test_simultaneous();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
